fifo_wr_arbiter: RTL

- Write-side controller for the dual-clock FIFO. Shares the FIFO write port among NUM_REQ requesters in the wt_clk domain.
- Grants are round-robin and burst-based. Each burst is bounded by MAX_BURST beats or a per-requester last flag.
- Drives the FIFO's wt_en/wdata directly and never writes while the FIFO reports full, so FIFO overflow is structurally impossible.
- A FIFO overflow pulse is flagged as a sticky error.

---
 rtl/fifo_wr_arb_pkg.sv | 14 +
 rtl/fifo_rr_pick.sv | 28 ++
 rtl/fifo_wr_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-side arbiter.
package fifo_wr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Width of the per-grant beat counter; at least one bit even for single-beat bursts.
    function automatic int unsigned beat_cnt_width(input int unsigned max_burst);
        return (max_burst <= 1) ? 1 : $clog2(max_burst);
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Round-robin picker: first set request at or after start_i, searching upward with wrap.
module fifo_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    start_i,
    output logic               found_o,
    output logic [ID_W-1:0]    winner_o
);

    int unsigned idx;

    // Scan from start_i; the first hit wins and later hits are ignored.
    always_comb begin
        found_o  = 1'b0;
        winner_o = '0;
        idx      = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(start_i) + i) % NUM_REQ;
            if (!found_o && req_i[ID_W'(idx)]) begin
                found_o  = 1'b1;
                winner_o = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter for the dual-clock FIFO: round-robin, burst-bounded grants of the
// FIFO write port; never writes while the FIFO is full, and flags overflow as sticky.
module fifo_wr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4,
    parameter int unsigned ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          wt_clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [ID_W-1:0]               active_id,
    output logic                          busy,
    output logic                          fifo_wt_en,
    output logic [DATA_WIDTH-1:0]         fifo_wdata,
    input  logic                          fifo_full,
    input  logic                          fifo_overflow,
    output logic                          err_overflow
);

    localparam int unsigned       CNT_W    = beat_cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [ID_W-1:0]   ID_LAST  = ID_W'(NUM_REQ - 1);

    arb_state_t           state_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [ID_W-1:0]      active_id_q;
    logic [CNT_W-1:0]     beat_cnt_q;
    logic [ID_W-1:0]      rr_ptr_q;     // highest-priority requester for the next IDLE pick
    logic                 err_q;

    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
    logic                  owner_req;
    logic                  owner_last;
    logic                  beat;
    logic                  rel;
    logic [ID_W-1:0]       next_id;
    logic [ID_W-1:0]       pick_start;
    logic                  pick_found;
    logic [ID_W-1:0]       pick_id;

    // Unpack the flat data bus so the owner's slice can be selected by index.
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign data_arr[k] = req_data[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // Beat and release decisions for the current owner; search starts after the owner while bursting.
    always_comb begin
        owner_req  = req[active_id_q];
        owner_last = req_last[active_id_q];
        beat       = (state_q == BURST) && !rst && owner_req && !fifo_full;
        rel        = (state_q == BURST) &&
                     ((beat && (owner_last || (beat_cnt_q == CNT_LAST))) || !owner_req);
        next_id    = (active_id_q == ID_LAST) ? '0 : active_id_q + ID_W'(1);
        pick_start = (state_q == BURST) ? next_id : rr_ptr_q;
    end

    fifo_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_i    (req),
        .start_i  (pick_start),
        .found_o  (pick_found),
        .winner_o (pick_id)
    );

    assign fifo_wt_en   = beat;
    assign ack          = beat ? (NUM_REQ'(1) << active_id_q) : '0;
    assign fifo_wdata   = (state_q == BURST) ? data_arr[active_id_q] : '0;
    assign gnt          = gnt_q;
    assign active_id    = active_id_q;
    assign busy         = (state_q == BURST);
    assign err_overflow = err_q;

    // Grant FSM: pick in IDLE, hand over without a bubble on release, count beats otherwise.
    always_ff @(posedge wt_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            active_id_q <= '0;
            beat_cnt_q  <= '0;
            rr_ptr_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            if (fifo_overflow) begin
                err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        state_q     <= BURST;
                        gnt_q       <= NUM_REQ'(1) << pick_id;
                        active_id_q <= pick_id;
                        beat_cnt_q  <= '0;
                    end
                end
                BURST: begin
                    if (rel) begin
                        rr_ptr_q <= next_id;
                        if (pick_found) begin
                            gnt_q       <= NUM_REQ'(1) << pick_id;
                            active_id_q <= pick_id;
                            beat_cnt_q  <= '0;
                        end else begin
                            state_q <= IDLE;
                            gnt_q   <= '0;
                        end
                    end else if (beat) begin
                        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

endmodule
